i2s_frame_gen: RTL and testbench

Generates the I2S bit clock, word-select and per-bit sequencing that drive `i2s_tx`, all derived from the 12.288 MHz master clock. It produces `o_sclk`, `o_lrclk`, a bit index with a valid qualifier, the channel select and a one-cycle frame-end pulse (`o_finish`) that tells `i2s_tx` to latch the next stereo sample. With default parameters the bit clock is 3.072 MHz and the frame rate is 48 kHz, with 32-bit slots in standard I2S (one-bit-delayed) format.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_frame_gen_if.sv | 28 ++
 rtl/i2s_sclk_div.sv | 40 ++++
 rtl/i2s_frame_gen.sv | 103 ++++++++++
 tb/tb_i2s_frame_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S constants and the frame generator state type.
package i2s_pkg;

  localparam int I2S_DATA_BIT  = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_SCLK_DIV  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_fg_state_t;

endpackage

// File: rtl/i2s_frame_gen_if.sv
// Control and timing bundle between the frame generator and its consumers (i2s_tx).
interface i2s_frame_gen_if import i2s_pkg::*; #(
  parameter int DATA_BIT = I2S_DATA_BIT
);
  localparam int CW = $clog2(DATA_BIT);

  logic          i_enable;
  logic          o_sclk;
  logic          o_lrclk;
  logic          o_sclk_fall;
  logic [CW-1:0] o_count;
  logic          o_count_valid;
  logic          o_count_lrclk;
  logic          o_finish;
  logic          o_running;

  modport master (
    input  i_enable,
    output o_sclk, o_lrclk, o_sclk_fall, o_count, o_count_valid,
           o_count_lrclk, o_finish, o_running
  );

  modport slave (
    output i_enable,
    input  o_sclk, o_lrclk, o_sclk_fall, o_count, o_count_valid,
           o_count_lrclk, o_finish, o_running
  );
endinterface

// File: rtl/i2s_sclk_div.sv
// Master-clock phase counter producing the registered bit clock and its falling-edge strobe.
module i2s_sclk_div #(
  parameter int SCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_sclk,
  output logic o_sclk_fall,
  output logic o_wrap,
  output logic o_fall_next
);
  localparam int            DW       = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2);

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_nxt;

  always_comb begin
    w_div_nxt = '0;
    if (!i_clear && (r_div_cnt != DIV_LAST)) w_div_nxt = r_div_cnt + DW'(1);
  end

  // o_wrap: the phase wraps on this edge; o_fall_next: the next cycle is the wrap cycle
  assign o_wrap      = !i_clear && (r_div_cnt == DIV_LAST);
  assign o_fall_next = !i_clear && (w_div_nxt == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt   <= '0;
      o_sclk      <= 1'b0;
      o_sclk_fall <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_nxt;
      o_sclk      <= !i_clear && (w_div_nxt >= DIV_HALF);
      o_sclk_fall <= o_fall_next;
    end
  end
endmodule

// File: rtl/i2s_frame_gen.sv
// I2S frame sequencer: run/stop FSM, slot bit counter, word select and data-bit decode.
module i2s_frame_gen import i2s_pkg::*; #(
  parameter int SCLK_DIV  = I2S_SCLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int DATA_BIT  = I2S_DATA_BIT
) (
  input  logic             i_clk_12_288,
  input  logic             i_reset_n,
  i2s_frame_gen_if.master  fg_if
);
  localparam int            BW       = $clog2(SLOT_BITS);
  localparam int            CW       = $clog2(DATA_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] DATA_HI  = BW'(DATA_BIT);

  i2s_fg_state_t r_state, w_state_nxt;
  logic [BW-1:0] r_bit_cnt, w_bit_nxt;
  logic          r_lrclk, w_lrclk_nxt;
  logic          w_clear, w_wrap, w_fall_next, w_sclk, w_sclk_fall;
  logic          w_valid_nxt, w_finish_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] r_count;
  logic          r_count_valid, r_count_lrclk, r_finish, r_running;

  assign w_clear = (r_state == IDLE);

  i2s_sclk_div #(.SCLK_DIV(SCLK_DIV)) u_sclk_div (
    .i_clk       (i_clk_12_288),
    .i_rst_n     (i_reset_n),
    .i_clear     (w_clear),
    .o_sclk      (w_sclk),
    .o_sclk_fall (w_sclk_fall),
    .o_wrap      (w_wrap),
    .o_fall_next (w_fall_next)
  );

  // STOP only leaves to IDLE on the frame-end cycle, so frames are never cut short
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fg_if.i_enable) w_state_nxt = RUN;
      RUN:     if (!fg_if.i_enable) w_state_nxt = STOP;
      STOP:    if (fg_if.i_enable) w_state_nxt = RUN;
               else if (r_finish) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_bit_nxt   = r_bit_cnt;
    w_lrclk_nxt = r_lrclk;
    if (w_clear) begin
      w_bit_nxt   = '0;
      w_lrclk_nxt = 1'b0;
    end else if (w_wrap) begin
      if (r_bit_cnt == BIT_LAST) begin
        w_bit_nxt   = '0;
        w_lrclk_nxt = !r_lrclk;
      end else begin
        w_bit_nxt = r_bit_cnt + BW'(1);
      end
    end
  end

  // Decode from next-state values so every output is a plain flop
  always_comb begin
    w_valid_nxt  = (w_bit_nxt != '0) && (w_bit_nxt <= DATA_HI);
    w_count_nxt  = w_valid_nxt ? CW'(DATA_HI - w_bit_nxt) : '0;
    w_finish_nxt = (w_state_nxt != IDLE) && w_lrclk_nxt &&
                   (w_bit_nxt == BIT_LAST) && w_fall_next;
  end

  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_lrclk       <= 1'b0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_count_lrclk <= 1'b0;
      r_finish      <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_lrclk       <= w_lrclk_nxt;
      r_count       <= w_count_nxt;
      r_count_valid <= w_valid_nxt;
      r_count_lrclk <= w_lrclk_nxt;
      r_finish      <= w_finish_nxt;
      r_running     <= (w_state_nxt != IDLE);
    end
  end

  assign fg_if.o_sclk        = w_sclk;
  assign fg_if.o_sclk_fall   = w_sclk_fall;
  assign fg_if.o_lrclk       = r_lrclk;
  assign fg_if.o_count       = r_count;
  assign fg_if.o_count_valid = r_count_valid;
  assign fg_if.o_count_lrclk = r_count_lrclk;
  assign fg_if.o_finish      = r_finish;
  assign fg_if.o_running     = r_running;
endmodule

// File: tb/tb_i2s_frame_gen.sv
// Directed bench for i2s_frame_gen with default parameters (DATA_BIT=24, 32-bit slots, /4 bit clock).
module tb_i2s_frame_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  i2s_frame_gen_if #(.DATA_BIT(24)) fg();

  i2s_frame_gen dut (
    .i_clk_12_288 (clk),
    .i_reset_n    (rst_n),
    .fg_if        (fg)
  );

  // Bench-side transmitter and I2S receiver for the link test
  logic [23:0] tx_l, tx_r, lat_l, lat_r, rx_sh, rx_l, rx_r;
  logic        sd, rx_lr = 1'b0;
  int          rx_pos = 1000;

  always @(posedge clk) if (fg.o_finish) begin
    lat_l <= tx_l;
    lat_r <= tx_r;
  end

  assign sd = fg.o_count_valid ? (fg.o_count_lrclk ? lat_r[fg.o_count] : lat_l[fg.o_count]) : 1'b0;

  always @(posedge fg.o_sclk) begin
    rx_lr <= fg.o_lrclk;
    if (fg.o_lrclk != rx_lr) rx_pos <= 0;
    else rx_pos <= rx_pos + 1;
    if (fg.o_lrclk == rx_lr && rx_pos >= 0 && rx_pos < 24) rx_sh <= {rx_sh[22:0], sd};
    if (fg.o_lrclk == rx_lr && rx_pos == 23) begin
      if (fg.o_lrclk) rx_r <= {rx_sh[22:0], sd};
      else            rx_l <= {rx_sh[22:0], sd};
    end
  end

  task automatic test_reset();
    int guard;
    rst_n = 1'b0;
    fg.i_enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fg.o_sclk, fg.o_lrclk, fg.o_sclk_fall, fg.o_count, fg.o_count_valid,
         fg.o_count_lrclk, fg.o_finish, fg.o_running} !== 12'h000) begin
      n_bad++; $display("FAIL reset_init: outputs not all zero, sclk=%b running=%b", fg.o_sclk, fg.o_running);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({fg.o_running, fg.o_sclk} !== 2'b00) begin
        n_bad++; $display("FAIL reset_idle: running/sclk=%b required 00", {fg.o_running, fg.o_sclk});
      end
    end
    // Run up to b=17 of the left slot, then pull reset mid-cycle
    fg.i_enable = 1'b1;
    guard = 0;
    while (!(fg.o_count_valid === 1'b1 && fg.o_lrclk === 1'b0 && fg.o_count === 5'd7) && guard < 300) begin
      @(negedge clk); guard++;
    end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL reset_reach_b17: timeout waiting for b=17"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fg.o_sclk, fg.o_lrclk, fg.o_sclk_fall, fg.o_count, fg.o_count_valid,
         fg.o_count_lrclk, fg.o_finish, fg.o_running} !== 12'h000) begin
      n_bad++; $display("FAIL reset_async: count=%0d valid=%b running=%b required all zero",
                        fg.o_count, fg.o_count_valid, fg.o_running);
    end
    fg.i_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({fg.o_running, fg.o_sclk} !== 2'b00) begin
        n_bad++; $display("FAIL reset_release_idle: running/sclk=%b required 00", {fg.o_running, fg.o_sclk});
      end
    end
  endtask

  task automatic test_steady();
    int ph, b, d, last_fin, n_fin;
    logic [6:0] got, exp;
    logic [4:0] e_count;
    logic e_valid, e_lr;
    fg.i_enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fg.o_running !== 1'b1) begin n_bad++; $display("FAIL startup_running: got %b required 1", fg.o_running); end
    last_fin = -1;
    n_fin = 0;
    for (int k = 0; k < 2560; k++) begin
      ph = k % 256; b = (ph % 128) / 4; d = ph % 4;
      e_lr    = (ph >= 128);
      e_valid = (b >= 1 && b <= 24);
      e_count = e_valid ? 5'(24 - b) : 5'd0;
      got = {fg.o_sclk, fg.o_lrclk, fg.o_sclk_fall, fg.o_count_valid, fg.o_count_lrclk, fg.o_finish, fg.o_running};
      exp = {(d >= 2), e_lr, (d == 3), e_valid, e_lr, (ph == 255), 1'b1};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL steady_ctrl k=%0d: got %b required %b", k, got, exp); end
      n_cmp++;
      if (fg.o_count !== e_count) begin n_bad++; $display("FAIL steady_count k=%0d: got %0d required %0d", k, fg.o_count, e_count); end
      if (fg.o_finish === 1'b1) begin
        n_fin++;
        if (last_fin >= 0) begin
          n_cmp++;
          if (k - last_fin != 256) begin n_bad++; $display("FAIL finish_period: got %0d required 256", k - last_fin); end
        end
        last_fin = k;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (n_fin != 10) begin n_bad++; $display("FAIL finish_count: got %0d required 10", n_fin); end
  endtask

  task automatic test_data_window();
    int guard, nv[2], seq_ok[2], exp_next[2];
    guard = 0;
    while (fg.o_finish !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL window_sync: no finish seen"); end
    nv = '{0, 0}; seq_ok = '{1, 1}; exp_next = '{23, 23};
    for (int ph = 0; ph < 256; ph++) begin
      @(negedge clk);
      n_cmp++;
      if (fg.o_count_lrclk !== fg.o_lrclk) begin
        n_bad++; $display("FAIL window_lrclk ph=%0d: count_lrclk=%b required %b", ph, fg.o_count_lrclk, fg.o_lrclk);
      end
      if (fg.o_count_valid === 1'b1) nv[ph / 128]++;
      if (ph % 4 == 2 && fg.o_count_valid === 1'b1) begin
        if (fg.o_count !== 5'(exp_next[ph / 128])) seq_ok[ph / 128] = 0;
        exp_next[ph / 128]--;
      end
      if (ph % 128 == 2 || ph % 128 == 102 || ph % 128 == 126) begin
        n_cmp++;
        if (fg.o_count_valid !== 1'b0) begin
          n_bad++; $display("FAIL window_edge ph=%0d: valid=%b required 0", ph, fg.o_count_valid);
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (nv[s] != 96) begin n_bad++; $display("FAIL window_len slot%0d: got %0d cycles required 96", s, nv[s]); end
      n_cmp++;
      if (seq_ok[s] != 1 || exp_next[s] != -1) begin
        n_bad++; $display("FAIL window_seq slot%0d: ok=%0d last=%0d required ok=1 last=-1", s, seq_ok[s], exp_next[s]);
      end
    end
  endtask

  task automatic test_stop();
    int guard, edges;
    logic prev;
    guard = 0;
    @(negedge clk);
    while (fg.o_finish !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL stop_sync: no finish seen"); end
    repeat (21) @(negedge clk);
    fg.i_enable = 1'b0;
    for (int ph = 20; ph < 256; ph++) begin
      n_cmp++;
      if ({fg.o_running, fg.o_finish} !== {1'b1, (ph == 255)}) begin
        n_bad++; $display("FAIL stop_drain ph=%0d: running/finish=%b required 1%b", ph, {fg.o_running, fg.o_finish}, (ph == 255));
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({fg.o_sclk, fg.o_lrclk, fg.o_count, fg.o_count_valid, fg.o_finish, fg.o_running} !== 10'h000) begin
      n_bad++; $display("FAIL stop_idle: running=%b sclk=%b required all zero", fg.o_running, fg.o_sclk);
    end
    edges = 0; prev = fg.o_sclk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fg.o_sclk !== prev) edges++;
      prev = fg.o_sclk;
    end
    n_cmp++;
    if (edges != 0 || fg.o_running !== 1'b0) begin
      n_bad++; $display("FAIL stop_quiet: sclk edges=%0d running=%b required 0/0", edges, fg.o_running);
    end
  endtask

  task automatic test_resume();
    int n_fin, guard;
    fg.i_enable = 1'b1;
    @(negedge clk);
    n_fin = 0;
    for (int k = 0; k < 768; k++) begin
      if (k == 40 || k == 300) fg.i_enable = 1'b0;
      if (k == 100 || k == 400) fg.i_enable = 1'b1;
      n_cmp++;
      if ({fg.o_running, fg.o_finish} !== {1'b1, (k % 256 == 255)}) begin
        n_bad++; $display("FAIL resume k=%0d: running/finish=%b required 1%b", k, {fg.o_running, fg.o_finish}, (k % 256 == 255));
      end
      if (fg.o_finish === 1'b1) n_fin++;
      @(negedge clk);
    end
    n_cmp++;
    if (n_fin != 3) begin n_bad++; $display("FAIL resume_finishes: got %0d required 3", n_fin); end
    fg.i_enable = 1'b0;
    guard = 0;
    while (fg.o_running !== 1'b0 && guard < 300) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL resume_shutdown: running still %b", fg.o_running); end
  endtask

  task automatic test_link();
    int guard;
    tx_l = 24'hA5F00F;
    tx_r = 24'h5A0FF0;
    fg.i_enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      guard = 0;
      while (fg.o_finish !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
      n_cmp++;
      if (guard >= 300) begin n_bad++; $display("FAIL link_sync: no finish in frame %0d", f); end
      if (f == 1) begin
        n_cmp++;
        if (rx_l !== 24'hA5F00F) begin n_bad++; $display("FAIL link_left: got %h required a5f00f", rx_l); end
        n_cmp++;
        if (rx_r !== 24'h5A0FF0) begin n_bad++; $display("FAIL link_right: got %h required 5a0ff0", rx_r); end
        tx_l = 24'h800001;
        tx_r = 24'h7FFFFE;
      end
      if (f == 2) begin
        n_cmp++;
        if (rx_l !== 24'h800001) begin n_bad++; $display("FAIL link_left2: got %h required 800001", rx_l); end
        n_cmp++;
        if (rx_r !== 24'h7FFFFE) begin n_bad++; $display("FAIL link_right2: got %h required 7ffffe", rx_r); end
      end
    end
    fg.i_enable = 1'b0;
    guard = 0;
    while (fg.o_running !== 1'b0 && guard < 300) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 300) begin n_bad++; $display("FAIL link_shutdown: running still %b", fg.o_running); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_data_window();
    test_stop();
    test_resume();
    test_link();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
